// File: rtl/axis_receiver.sv
// Byte-link receiver: buffers incoming bytes in a FIFO and drains them as an
// AXI4-Stream master framed into fixed-length packets.
module axis_receiver #(
  parameter int DATA_W       = 8,
  parameter int DEPTH        = 256,
  parameter int ADDR_W       = 8,
  parameter int AFULL_MARGIN = 4,
  parameter int PKT_LEN      = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] in_bits,
  input  logic              in_valid,
  output logic              rcv_data_ready,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              m_axis_tlast,
  output logic [ADDR_W:0]   fifo_count,
  output logic              overflow
);

  // state     | meaning
  // OUT_EMPTY | output register holds no byte (tvalid=0)
  // OUT_FULL  | output register holds a byte offered downstream (tvalid=1)
  typedef enum logic {OUT_EMPTY, OUT_FULL} out_state_t;

  localparam int BEAT_W = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
  localparam logic [ADDR_W:0]   CNT_FULL  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   CNT_AFULL = (ADDR_W+1)'(DEPTH - AFULL_MARGIN);
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(PKT_LEN - 1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   count;
  logic [ADDR_W:0]   count_next;
  logic [BEAT_W-1:0] beat;
  logic [DATA_W-1:0] tdata_q;
  logic              rdy_q;
  logic              ovf_q;
  logic              wr_en;
  logic              ld;
  logic              handshake;
  out_state_t        state;
  out_state_t        state_next;

  // A full memory never accepts, even if the output register drains this edge.
  assign wr_en     = in_valid && (count != CNT_FULL);
  assign handshake = (state == OUT_FULL) && m_axis_tready;

  always_comb begin
    state_next = state;
    ld         = 1'b0;
    case (state)
      OUT_EMPTY: begin
        if (count != '0) begin
          ld         = 1'b1;
          state_next = OUT_FULL;
        end
      end
      OUT_FULL: begin
        if (m_axis_tready) begin
          if (count != '0) begin
            ld = 1'b1;
          end else begin
            state_next = OUT_EMPTY;
          end
        end
      end
      default: state_next = OUT_EMPTY;
    endcase
  end

  always_comb begin
    count_next = count;
    case ({wr_en, ld})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= in_bits;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= OUT_EMPTY;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      tdata_q <= '0;
      beat    <= '0;
      rdy_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state <= state_next;
      count <= count_next;
      rdy_q <= (count_next < CNT_AFULL);
      if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (ld) begin
        tdata_q <= mem[rd_ptr];
        rd_ptr  <= rd_ptr + 1'b1;
      end
      if (in_valid && (count == CNT_FULL)) begin
        ovf_q <= 1'b1;
      end
      if (handshake) begin
        beat <= (beat == BEAT_LAST) ? '0 : beat + 1'b1;
      end
    end
  end

  assign rcv_data_ready = rdy_q;
  assign m_axis_tdata   = tdata_q;
  assign m_axis_tvalid  = (state == OUT_FULL);
  assign m_axis_tlast   = (state == OUT_FULL) && (beat == BEAT_LAST);
  assign fifo_count     = count;
  assign overflow       = ovf_q;

endmodule
